xcorr_seq: RTL
==============

# xcorr_seq

Sequencer for the complex-correlation accelerator in the sigma SoC. Holds a sliding window of 2*WIND_SIZE packed complex samples (imag[15:8], real[7:0], signed 8-bit each), accepts one sample pair per push, and once the window is full issues every (j,k), k>=j, product pair to the external MAC/accumulator datapath with the target accumulator index. Sits between the bus-facing accelerator CSR logic, which pushes samples and clears, and the MAC array, which computes a*conj(b) and accumulates into the result buffer.

## Interface
- WIND_SIZE, 3, half-window depth W; window holds N=2W samples; NRES=N(N+1)/2 accumulators (21 at default)
- IDX_W, $clog2(NRES), accumulator index width (5 at default)
- clk_i  in  1  clock
- arst_n_i  in  1  reset, asynchronous, active-low
- smp_valid_i  in  1  sample-pair push request
- smp_data_i  in  32  {odd sample[31:16], even sample[15:0]}
- smp_ready_o  out  1  push accepted when valid&ready
- clear_i  in  1  clear window fill and request accumulator clear
- mac_valid_o  out  1  operand pair valid
- mac_ready_i  in  1  MAC accepts pair
- mac_a_o  out  16  operand a = window[j]
- mac_b_o  out  16  operand b = window[k] (MAC conjugates)
- mac_idx_o  out  IDX_W  accumulator index
- mac_last_o  out  1  last pair of pass
- acc_clr_o  out  1  one-cycle accumulator clear pulse
- busy_o  out  1  pass in progress
- done_o  out  1  one-cycle pulse at pass end
- pass_cnt_o  out  16  completed passes since clear/reset

## Operation
- Window: lower half w[0..W-1], upper half w[W..N-1]. On accepted push: w[i]<=w[i+1] for i<W-1, w[W-1]<=even; w[W+i]<=w[W+i+1] for i<W-1, w[N-1]<=odd.
- fill_cnt saturates at W; increments per accepted push. A pass is triggered by the push that makes fill_cnt==W and by every later push.
- States: IDLE, ISSUE, DONE.
  - IDLE: smp_ready_o = ~clear_i. clear_i: fill_cnt<=0, window<=0, pass_cnt<=0, acc_clr_o pulses next cycle. Push with fill_cnt+1<W: stay IDLE. Triggering push: j<=0, k<=0, base<=0 -> ISSUE.
  - ISSUE: mac_valid_o=1, mac_a_o=w[j], mac_b_o=w[k], mac_idx_o=base+(k-j), mac_last_o=(j==N-1). On handshake: if k<N-1 then k++; else base<=base+(N-j), j++, k<=j+1. Handshake with mac_last_o -> DONE.
  - DONE: done_o=1, pass_cnt++ (wraps at 2^16), -> IDLE.
- Issue order yields indices 0..NRES-1 strictly ascending, each exactly once per pass.
- clear_i outside IDLE ignored. clear_i and smp_valid_i together in IDLE: clear wins, push not accepted.
- No arithmetic on sample data; widths of j,k = $clog2(N), base = IDX_W.

## Timing
- Reset values: mac_valid_o, mac_a_o, mac_b_o, mac_idx_o, mac_last_o, acc_clr_o, busy_o, done_o, pass_cnt_o = 0; smp_ready_o=1 (IDLE); window and fill_cnt = 0.
- Reset mid-pass: immediate return to IDLE, window/fill_cnt cleared, no acc_clr_o, no done_o.
- smp_ready_o combinational from state and clear_i; all other outputs registered.
- Triggering push accepted cycle T: mac_valid_o high T+1. With mac_ready_i held 1: pairs issued T+1..T+NRES, done_o at T+NRES+1, smp_ready_o high again at T+NRES+2 (23 cycles at default).
- mac_valid_o never drops and operands/index never change until handshake; mac_ready_i stalls extend ISSUE one cycle each.
- busy_o high in ISSUE and DONE.
- acc_clr_o asserted exactly one cycle, the cycle after clear_i sampled in IDLE.

## Test plan
- Fill/trigger: after reset push 0x07074121, 0x7132910B, 0x32017164 with mac_ready_i=1 -> no mac_valid_o after first two; after third, 21 pairs, first a=b=0x4121 idx 0, idx 5 a=0x4121 b=0x3201, last a=b=0x3201 idx 20 with mac_last_o; done_o at T+22; pass_cnt_o=1.
- Slide: then push 0x0AB1D159 -> window lower {910B,7164,D159}, upper {7132,3201,0AB1}; first pair a=b=0x910B; pass_cnt_o=2.
- Backpressure: mac_ready_i random 50% during pass -> operands stable while stalled, indices 0..20 each once in order, smp_ready_o low until return to IDLE.
- Clear: clear_i one cycle in IDLE after a pass -> acc_clr_o pulse next cycle, pass_cnt_o=0; next two pushes issue nothing, third triggers pass; clear_i during ISSUE -> no effect.
- Clear+push same cycle in IDLE -> smp_ready_o=0, push dropped, fill_cnt=0.
- Reset mid-pass: assert arst_n_i at issue index 10 -> all outputs 0 immediately, no done_o; three new pushes required before next pass.

Source files
------------

// File: rtl/xcorr_seq_if.sv
// xcorr_seq_if: sample-push and MAC-issue signals of the correlation sequencer
interface xcorr_seq_if #(parameter int IDX_W = 5);
  logic             smp_valid_i;
  logic [31:0]      smp_data_i;
  logic             smp_ready_o;
  logic             clear_i;
  logic             mac_valid_o;
  logic             mac_ready_i;
  logic [15:0]      mac_a_o;
  logic [15:0]      mac_b_o;
  logic [IDX_W-1:0] mac_idx_o;
  logic             mac_last_o;
  logic             acc_clr_o;
  logic             busy_o;
  logic             done_o;
  logic [15:0]      pass_cnt_o;
  modport slave (
    input  smp_valid_i, smp_data_i, clear_i, mac_ready_i,
    output smp_ready_o, mac_valid_o, mac_a_o, mac_b_o, mac_idx_o, mac_last_o,
           acc_clr_o, busy_o, done_o, pass_cnt_o
  );
  modport master (
    output smp_valid_i, smp_data_i, clear_i, mac_ready_i,
    input  smp_ready_o, mac_valid_o, mac_a_o, mac_b_o, mac_idx_o, mac_last_o,
           acc_clr_o, busy_o, done_o, pass_cnt_o
  );
endinterface

// File: rtl/xcorr_seq.sv
// xcorr_seq: sliding complex-sample window that issues every (j,k>=j) operand
// pair with its accumulator index to the MAC array once the window is full.
module xcorr_seq #(
  parameter int WIND_SIZE = 3,
  parameter int IDX_W     = $clog2(2*WIND_SIZE*(2*WIND_SIZE+1)/2)
) (
  input logic        clk_i,
  input logic        arst_n_i,
  xcorr_seq_if.slave bus
);
  localparam int W  = WIND_SIZE;
  localparam int N  = 2*W;
  localparam int JW = $clog2(N);
  localparam int FW = $clog2(W+1);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t           state_q, state_d;
  logic [15:0]      win_q [N];
  logic [15:0]      win_d [N];
  logic [FW-1:0]    fill_q, fill_d;
  logic [JW-1:0]    j_q, j_d, k_q, k_d;
  logic [IDX_W-1:0] base_q, base_d, idx_q, idx_d;
  logic [15:0]      pass_q, pass_d, a_q, a_d, b_q, b_d;
  logic             valid_q, valid_d, last_q, last_d, clr_q, clr_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             push;
  assign bus.smp_ready_o = (state_q == IDLE) && !bus.clear_i;
  assign push            = bus.smp_valid_i && bus.smp_ready_o;
  assign bus.mac_valid_o = valid_q;
  assign bus.mac_a_o     = a_q;
  assign bus.mac_b_o     = b_q;
  assign bus.mac_idx_o   = idx_q;
  assign bus.mac_last_o  = last_q;
  assign bus.acc_clr_o   = clr_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.pass_cnt_o  = pass_q;
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    fill_d  = fill_q;
    j_d     = j_q;
    k_d     = k_q;
    base_d  = base_q;
    pass_d  = pass_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_i) begin
          win_d  = '{default: '0};
          fill_d = '0;
          pass_d = '0;
          clr_d  = 1'b1;
        end else if (push) begin
          for (int i = 0; i < W-1; i++) begin
            win_d[i]   = win_q[i+1];
            win_d[W+i] = win_q[W+i+1];
          end
          win_d[W-1] = bus.smp_data_i[15:0];
          win_d[N-1] = bus.smp_data_i[31:16];
          fill_d     = (fill_q == FW'(W)) ? fill_q : fill_q + FW'(1);
          if (fill_q >= FW'(W-1)) begin
            j_d     = '0;
            k_d     = '0;
            base_d  = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.mac_ready_i) begin
          if (last_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            pass_d  = pass_q + 16'd1;
            state_d = DONE;
          end else if (k_q < JW'(N-1)) begin
            k_d = k_q + JW'(1);
          end else begin
            // next row starts on the diagonal; base skips the row just finished
            base_d = base_q + IDX_W'(N) - IDX_W'(j_q);
            j_d    = j_q + JW'(1);
            k_d    = j_q + JW'(1);
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
    a_d    = valid_d ? win_d[j_d] : '0;
    b_d    = valid_d ? win_d[k_d] : '0;
    idx_d  = valid_d ? base_d + IDX_W'(k_d) - IDX_W'(j_d) : '0;
    last_d = valid_d && (j_d == JW'(N-1));
  end
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      win_q   <= '{default: '0};
      fill_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
      base_q  <= '0;
      pass_q  <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      j_q     <= j_d;
      k_q     <= k_d;
      base_q  <= base_d;
      pass_q  <= pass_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule
